// File: rtl/arb_req_if.sv
// Command and arbiter handshake bundle for one arb_req_master client.
interface arb_req_if #(
   parameter int LEN_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_slow;
   logic             req;
   logic             gnt;
   logic             done;
   logic             dly;
   logic             tout_rst;
   logic             tout;
   logic             beat_en;
   logic [LEN_W-1:0] beat_idx;
   logic             job_ok;
   logic             job_err;

   modport master (
      input  cmd_valid, cmd_len, cmd_slow, gnt, tout,
      output cmd_ready, req, done, dly, tout_rst, beat_en, beat_idx, job_ok, job_err
   );

   modport slave (
      output cmd_valid, cmd_len, cmd_slow, gnt, tout,
      input  cmd_ready, req, done, dly, tout_rst, beat_en, beat_idx, job_ok, job_err
   );
endinterface

// File: rtl/arb_req_master.sv
// Arbiter requester: request, count granted beats, close with done/dly or recover from tout.
// Define ARB_REQ_RETRY_EN to re-request after a timeout (up to MAX_RETRY times, BACKOFF idle cycles apart).
//
// state     | meaning
// S_IDLE    | ready for a command
// S_REQ     | req high, waiting for gnt
// S_XFER    | counting granted beats
// S_DONE    | done/job_ok pulse, dly from cmd_slow
// S_RECOV   | tout_rst pulse to clear arbiter TIMEOUT
// S_BACKOFF | idle gap before re-request
module arb_req_master #(
   parameter int LEN_W     = 4,
   parameter int MAX_RETRY = 2,
   parameter int BACKOFF   = 3
) (
   input  logic      clk,
   input  logic      rst,
   arb_req_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_XFER, S_DONE, S_RECOV, S_BACKOFF
   } state_t;

   if (BACKOFF < 1) begin : g_bad_backoff
      $error("arb_req_master: BACKOFF must be at least 1");
   end
   if (MAX_RETRY < 0) begin : g_bad_retry
      $error("arb_req_master: MAX_RETRY must not be negative");
   end

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len_q, len_nxt;
   logic             slow_q, slow_nxt;
   logic [LEN_W-1:0] beat_idx_q, idx_nxt;
   logic             beat_en_q, ben_nxt;
   logic             err_nxt;
   logic             cmd_ready_q, req_q, done_q, dly_q, tout_rst_q, job_ok_q, job_err_q;

`ifdef ARB_REQ_RETRY_EN
   localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int BO_W = (BACKOFF < 2) ? 1 : $clog2(BACKOFF);
   logic [RC_W-1:0] retry_cnt, retry_nxt;
   logic [BO_W-1:0] bo_cnt, bo_nxt;
`endif

   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      slow_nxt  = slow_q;
      idx_nxt   = beat_idx_q;
      ben_nxt   = 1'b0;
      err_nxt   = 1'b0;
`ifdef ARB_REQ_RETRY_EN
      retry_nxt = retry_cnt;
      bo_nxt    = bo_cnt;
`endif
      case (state)
         S_IDLE: begin
            idx_nxt = '0;
            if (bus.cmd_valid) begin
               len_nxt   = (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
               slow_nxt  = bus.cmd_slow;
               state_nxt = S_REQ;
`ifdef ARB_REQ_RETRY_EN
               retry_nxt = '0;
`endif
            end
         end
         S_REQ: begin
            idx_nxt = '0;
            if (bus.tout) begin
               state_nxt = S_RECOV;
            end else if (bus.gnt) begin
               state_nxt = S_XFER;
               ben_nxt   = 1'b1;
            end
         end
         S_XFER: begin
            // tout wins over a completing last beat; the partial count is dropped
            if (bus.tout) begin
               state_nxt = S_RECOV;
               idx_nxt   = '0;
            end else if (beat_en_q && (beat_idx_q == len_q - LEN_W'(1))) begin
               state_nxt = S_DONE;
               idx_nxt   = '0;
            end else begin
               ben_nxt = bus.gnt;
               idx_nxt = beat_idx_q + LEN_W'(beat_en_q);
            end
         end
         S_DONE: state_nxt = S_IDLE;
         S_RECOV: begin
`ifdef ARB_REQ_RETRY_EN
            if (retry_cnt < RC_W'(MAX_RETRY)) begin
               state_nxt = S_BACKOFF;
               bo_nxt    = BO_W'(BACKOFF - 1);
            end else begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end
`else
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
`endif
         end
         S_BACKOFF: begin
`ifdef ARB_REQ_RETRY_EN
            if (bo_cnt == '0) begin
               state_nxt = S_REQ;
               retry_nxt = retry_cnt + RC_W'(1);
            end else begin
               bo_nxt = bo_cnt - BO_W'(1);
            end
`else
            state_nxt = S_IDLE;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         len_q       <= LEN_W'(1);
         slow_q      <= 1'b0;
         beat_idx_q  <= '0;
         beat_en_q   <= 1'b0;
         cmd_ready_q <= 1'b1;
         req_q       <= 1'b0;
         done_q      <= 1'b0;
         dly_q       <= 1'b0;
         tout_rst_q  <= 1'b0;
         job_ok_q    <= 1'b0;
         job_err_q   <= 1'b0;
`ifdef ARB_REQ_RETRY_EN
         retry_cnt   <= '0;
         bo_cnt      <= '0;
`endif
      end else begin
         state       <= state_nxt;
         len_q       <= len_nxt;
         slow_q      <= slow_nxt;
         beat_idx_q  <= idx_nxt;
         beat_en_q   <= ben_nxt;
         cmd_ready_q <= (state_nxt == S_IDLE);
         req_q       <= (state_nxt == S_REQ);
         done_q      <= (state_nxt == S_DONE);
         dly_q       <= (state_nxt == S_DONE) && slow_nxt;
         tout_rst_q  <= (state_nxt == S_RECOV);
         job_ok_q    <= (state_nxt == S_DONE);
         job_err_q   <= err_nxt;
`ifdef ARB_REQ_RETRY_EN
         retry_cnt   <= retry_nxt;
         bo_cnt      <= bo_nxt;
`endif
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.req       = req_q;
   assign bus.done      = done_q;
   assign bus.dly       = dly_q;
   assign bus.tout_rst  = tout_rst_q;
   assign bus.beat_en   = beat_en_q;
   assign bus.beat_idx  = beat_idx_q;
   assign bus.job_ok    = job_ok_q;
   assign bus.job_err   = job_err_q;
endmodule

// File: tb/tb_arb_req_master.sv
// Bench for arb_req_master: directed vector table plus randomized jobs from a phase-level model.
module tb_arb_req_master;
   localparam int MAX_RETRY = 2;
   localparam int BACKOFF   = 3;

   typedef struct packed {
      logic        chk;
      logic        rst;
      logic        cv;
      logic [3:0]  len;
      logic        slow;
      logic        gnt;
      logic        tout;
      logic [13:0] exp;
   } vec_t;

   logic clk;
   logic rst;
   int   nvec;
   int   nerr;
   vec_t q[$];

   arb_req_if #(.LEN_W(4)) bus ();

   arb_req_master #(.LEN_W(4), .MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // expected outputs packed as {cmd_ready, req, done, dly, tout_rst, beat_en, beat_idx, job_ok, job_err}
   function automatic logic [13:0] ex(input bit rdy, input bit rq, input bit dn, input bit dl,
                                      input bit tr, input bit be, input int idx, input bit ok,
                                      input bit er);
      logic [3:0] i4;
      i4 = 4'(idx);
      return {rdy, rq, dn, dl, tr, be, i4, ok, er};
   endfunction

   function automatic logic [13:0] e_idle();          return ex(1, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
   function automatic logic [13:0] e_req();           return ex(0, 1, 0, 0, 0, 0, 0, 0, 0); endfunction
   function automatic logic [13:0] e_x(bit be, int i); return ex(0, 0, 0, 0, 0, be, i, 0, 0); endfunction
   function automatic logic [13:0] e_done(bit dl);    return ex(0, 0, 1, dl, 0, 0, 0, 1, 0); endfunction
   function automatic logic [13:0] e_trst();          return ex(0, 0, 0, 0, 1, 0, 0, 0, 0); endfunction
   function automatic logic [13:0] e_err();           return ex(1, 0, 0, 0, 0, 0, 0, 0, 1); endfunction
   function automatic logic [13:0] e_zero();          return ex(0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction

   task automatic add(input bit chk, input bit r, input bit cv, input int len, input bit slow,
                      input bit g, input bit t, input logic [13:0] e);
      vec_t v;
      v = '{chk: chk, rst: r, cv: cv, len: 4'(len), slow: slow, gnt: g, tout: t, exp: e};
      q.push_back(v);
   endtask

   // each entry: outputs expected before this cycle's inputs are applied, then the inputs
   task automatic push(input bit r, input bit cv, input int len, input bit slow,
                       input bit g, input bit t, input logic [13:0] e);
      add(1'b1, r, cv, len, slow, g, t, e);
   endtask

   task automatic run_q(input string tag);
      logic [13:0] act;
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         if (q[i].chk) begin
            nvec++;
            act = {bus.cmd_ready, bus.req, bus.done, bus.dly, bus.tout_rst, bus.beat_en,
                   bus.beat_idx, bus.job_ok, bus.job_err};
            if (act !== q[i].exp) begin
               nerr++;
               $display("FAIL %s vec %0d: got rdy/req/done/dly/trst/ben/idx/ok/err=%b required %b",
                        tag, i, act, q[i].exp);
            end
         end
         rst           = q[i].rst;
         bus.cmd_valid = q[i].cv;
         bus.cmd_len   = q[i].len;
         bus.cmd_slow  = q[i].slow;
         bus.gnt       = q[i].gnt;
         bus.tout      = q[i].tout;
      end
      q.delete();
   endtask

   // Reference built from job phases: accept, d request cycles, beats (a beat follows each
   // sampled gnt), then done, or tout -> tout_rst -> retry/backoff or job_err.
   task automatic gen_job();
      int len, leff, d, tat, tries, cyc, beats;
      bit slow, to, ben, g;
      len   = $urandom_range(0, 15);
      leff  = (len == 0) ? 1 : len;
      slow  = 1'($urandom_range(0, 1));
      tries = 0;
      push(0, 1, len, slow, 0, 0, e_idle());
      forever begin
         d   = $urandom_range(1, 4);
         tat = ($urandom_range(0, 2) == 0) ? $urandom_range(0, d + 2 * leff) : -1;
         cyc = 0;
         to  = 1'b0;
         for (int i = 0; i < d && !to; i++) begin
            to = (cyc == tat);
            push(0, 0, 0, 0, i == d - 1, to, e_req());
            cyc++;
         end
         if (!to) begin
            beats = 0;
            ben   = 1'b1;
            while (1) begin
               g  = ($urandom_range(0, 3) != 0);
               to = (cyc == tat);
               push(0, 0, 0, 0, g, to, e_x(ben, beats));
               cyc++;
               if (to) break;
               if (ben && beats == leff - 1) break;
               beats += int'(ben);
               ben = g;
            end
         end
         if (!to) begin
            push(0, 0, 0, 0, 0, 0, e_done(slow));
            return;
         end
         push(0, 0, 0, 0, 0, 0, e_trst());
`ifdef ARB_REQ_RETRY_EN
         if (tries < MAX_RETRY) begin
            repeat (BACKOFF) push(0, 0, 0, 0, 0, 0, e_zero());
            tries++;
            continue;
         end
`endif
         push(0, 0, 0, 0, 0, 0, e_err());
         return;
      end
   endtask

   initial begin
      clk           = 1'b0;
      rst           = 1'b1;
      nvec          = 0;
      nerr          = 0;
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.cmd_slow  = 1'b0;
      bus.gnt       = 1'b0;
      bus.tout      = 1'b0;

      // reset held 2 cycles with cmd_valid high
      add(0, 1, 1, 3, 0, 0, 0, e_zero());
      push(1, 1, 3, 0, 0, 0, e_idle());
      push(0, 0, 0, 0, 0, 0, e_idle());
      push(0, 0, 0, 0, 0, 0, e_idle());
      // normal job, len 3, gnt 2 cycles after req
      push(0, 1, 3, 0, 0, 0, e_idle());
      push(0, 0, 0, 0, 0, 0, e_req());
      push(0, 0, 0, 0, 1, 0, e_req());
      push(0, 0, 0, 0, 1, 0, e_x(1, 0));
      push(0, 0, 0, 0, 1, 0, e_x(1, 1));
      push(0, 0, 0, 0, 1, 0, e_x(1, 2));
      push(0, 0, 0, 0, 0, 0, e_done(0));
      // slow job, len 2, gnt dropped once mid-transfer
      push(0, 1, 2, 1, 0, 0, e_idle());
      push(0, 0, 0, 0, 1, 0, e_req());
      push(0, 0, 0, 0, 0, 0, e_x(1, 0));
      push(0, 0, 0, 0, 1, 0, e_x(0, 1));
      push(0, 0, 0, 0, 1, 0, e_x(1, 1));
      push(0, 0, 0, 0, 0, 0, e_done(1));
      // zero length behaves as one beat
      push(0, 1, 0, 0, 0, 0, e_idle());
      push(0, 0, 0, 0, 1, 0, e_req());
      push(0, 0, 0, 0, 1, 0, e_x(1, 0));
      push(0, 0, 0, 0, 0, 0, e_done(0));
      // tout on the last beat
      push(0, 1, 2, 1, 0, 0, e_idle());
      push(0, 0, 0, 0, 1, 0, e_req());
      push(0, 0, 0, 0, 1, 0, e_x(1, 0));
      push(0, 0, 0, 0, 1, 1, e_x(1, 1));
      push(0, 0, 0, 0, 0, 0, e_trst());
`ifdef ARB_REQ_RETRY_EN
      repeat (MAX_RETRY) begin
         repeat (BACKOFF) push(0, 0, 0, 0, 0, 0, e_zero());
         push(0, 0, 0, 0, 1, 1, e_req());
         push(0, 0, 0, 0, 0, 0, e_trst());
      end
`endif
      push(0, 0, 0, 0, 0, 0, e_err());
      // reset mid-transfer, then a fresh job
      push(0, 1, 3, 0, 0, 0, e_idle());
      push(0, 0, 0, 0, 1, 0, e_req());
      push(0, 0, 0, 0, 1, 0, e_x(1, 0));
      push(1, 0, 0, 0, 1, 0, e_x(1, 1));
      push(0, 0, 0, 0, 0, 0, e_idle());
      push(0, 1, 1, 1, 0, 0, e_idle());
      push(0, 0, 0, 0, 1, 0, e_req());
      push(0, 0, 0, 0, 0, 0, e_x(1, 0));
      push(0, 0, 0, 0, 0, 0, e_done(1));
      push(0, 0, 0, 0, 0, 0, e_idle());
      run_q("directed");

      for (int j = 0; j < 60; j++) gen_job();
      push(0, 0, 0, 0, 0, 0, e_idle());
      run_q("random");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/arb_req_master.md
Name: arb_req_master

Overview:
- Upstream requester for the arbiter.
- Accepts a transfer command, raises req, waits for gnt, then counts out the granted data beats.
- Closes the grant with done/dly, or recovers from an arbiter timeout (tout) by pulsing the arbiter's reset input.
- One instance per bus client; its outputs drive the arbiter's req/done/dly/reset inputs, and it consumes the arbiter's gnt/tout.

Parameters:
- LEN_W, 4: width of cmd_len and the internal beat counter.
- MAX_RETRY, 2: number of re-requests after a timeout (used only with ARB_REQ_RETRY_EN).
- BACKOFF, 3: idle cycles between a timeout recovery and the re-request (≥1).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_len  in  LEN_W  beat count; 0 is treated as 1.
- cmd_slow  in  1  request arbiter WAIT state on completion (drives dly).
- req  out  1  to arbiter req.
- gnt  in  1  from arbiter; high while arbiter is BUSY.
- done  out  1  to arbiter done; 1-cycle pulse.
- dly  out  1  to arbiter dly.
- tout_rst  out  1  to arbiter reset; 1-cycle pulse.
- tout  in  1  from arbiter; high while arbiter is in TIMEOUT.
- beat_en  out  1  data beat strobe.
- beat_idx  out  LEN_W  index of the current beat, counting from 0.
- job_ok  out  1  1-cycle pulse on successful completion.
- job_err  out  1  1-cycle pulse on abandoned job.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- rst=1 at a posedge forces S_IDLE and clears all counters.
  - Outputs after reset: req=0, done=0, dly=0, tout_rst=0, beat_en=0, beat_idx=0, job_ok=0, job_err=0, cmd_ready=1 (first cycle after reset).
  - rst mid-job drops the job silently: no job_ok/job_err.
- States: S_IDLE, S_REQ, S_XFER, S_DONE, S_RECOV, S_BACKOFF.
- S_IDLE:
  - cmd_ready=1; all other outputs 0.
  - On cmd_valid: latch len (0→1) and slow; clear retry_cnt; go to S_REQ.
  - cmd_ready is 0 in every other state; only one job is in flight.
- S_REQ:
  - req=1.
  - gnt=1 → go to S_XFER; req drops on the same edge.
  - tout=1 → go to S_RECOV.
  - No internal timeout; waits indefinitely for gnt.
- S_XFER:
  - beat_en=1 on every cycle that gnt=1; beat_idx increments after each beat.
  - Last beat (beat_idx == len-1 with beat_en) → go to S_DONE.
  - gnt=0 with tout=0 stalls: beat_en=0, counter holds.
- tout priority: tout=1 in S_REQ or S_XFER takes priority over gnt and over last-beat completion in the same cycle → go to S_RECOV. The partial beat count is discarded.
- S_DONE:
  - One cycle: done=1, dly=slow, job_ok=1.
  - Then go to S_IDLE; dly returns to 0.
- S_RECOV:
  - One cycle: tout_rst=1, dly=0, so the arbiter takes TIMEOUT→FREE.
  - Then go to S_BACKOFF or S_IDLE (see Optional Feature).
- S_BACKOFF:
  - BACKOFF cycles, all outputs 0; then go to S_REQ with retry_cnt+1.
  - beat_idx resets to 0 on every entry to S_REQ.
- Latency: cmd accept → req high takes 1 cycle. gnt sampled high → first beat_en takes 1 cycle. Last beat → done takes 1 cycle.
- Invariants:
  - done and tout_rst are never high together.
  - req is never high in S_XFER, S_DONE, S_RECOV or S_BACKOFF.

Optional Feature:
- Macro: ARB_REQ_RETRY_EN.
- Defined:
  - After S_RECOV, if retry_cnt < MAX_RETRY, go to S_BACKOFF.
  - Otherwise pulse job_err for 1 cycle (same cycle as the S_IDLE entry) and go to S_IDLE.
- Undefined:
  - S_BACKOFF, retry_cnt and BACKOFF are unused.
  - S_RECOV always pulses job_err and goes to S_IDLE; MAX_RETRY is ignored.

Test Plan:
- Reset: hold rst=1 for 2 cycles with cmd_valid=1 → all outputs 0, cmd_ready=1 one cycle after release, no command accepted during reset.
- Normal job: cmd_len=3, cmd_slow=0, gnt returned 2 cycles after req →
  - beat_en high 3 consecutive cycles, beat_idx 0,1,2;
  - then done=1, dly=0, job_ok=1 for 1 cycle; back to cmd_ready=1.
- Slow job with stall: cmd_len=2, cmd_slow=1, gnt dropped for 1 cycle mid-transfer → exactly 2 beats (stall cycle has beat_en=0), then done=1 with dly=1 for 1 cycle.
- Zero length: cmd_len=0 → exactly 1 beat, then done.
- Timeout during transfer: tout=1 on the cycle of the last beat →
  - no done;
  - tout_rst=1, dly=0 for 1 cycle;
  - with ARB_REQ_RETRY_EN: req reasserts after BACKOFF=3 idle cycles; after 3 timeouts (MAX_RETRY=2), job_err=1 once.
  - without ARB_REQ_RETRY_EN: job_err=1 immediately after tout_rst.
- Reset mid-job: rst=1 during S_XFER → next cycle outputs match the reset values listed in Behaviour, no job_ok/job_err; a new command is accepted normally.
